// File: rtl/text_mem_loader_pkg.sv
// Shared types and defaults for the text memory loader and its readers.
package text_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] TERM_CHAR_DEF = 8'h00;
    localparam logic [7:0] PRINT_LO      = 8'h20;
    localparam logic [7:0] PRINT_HI      = 8'h7E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        TERM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/text_mem_loader_if.sv
// Byte-stream input and memory write-port bundle of the text memory loader.
// dropped_cnt exists only when ASCII_FILTER_EN is defined.
interface text_mem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_din;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] length;
`ifdef ASCII_FILTER_EN
    logic [ADDR_W-1:0] dropped_cnt;
`endif

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_waddr, mem_din,
        input  busy, done, overflow, length
`ifdef ASCII_FILTER_EN
        , input dropped_cnt
`endif
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_waddr, mem_din,
        output busy, done, overflow, length
`ifdef ASCII_FILTER_EN
        , output dropped_cnt
`endif
    );

endinterface

// File: rtl/text_mem_loader_chk.sv
// Combinational printable-ASCII range check used by the optional input filter.
module ascii_printable_chk
    import text_mem_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_ch,
    output logic              o_ok
);

    assign o_ok = (i_ch >= DATA_W'(PRINT_LO)) && (i_ch <= DATA_W'(PRINT_HI));

endmodule

// File: rtl/text_mem_loader.sv
// Streams ASCII bytes into the text memory from address 0 and terminates the string.
// Define ASCII_FILTER_EN to drop non-printable bytes and expose dropped_cnt.
module text_mem_loader
    import text_mem_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(TERM_CHAR_DEF)
) (
    input logic              clk,
    input logic              rst,
    text_mem_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_length;
    logic [DATA_W-1:0] r_din;
    logic              r_we;
    logic              r_done;
    logic              r_overflow;

    logic w_ready;
    logic w_acc;
    logic w_keep;
    logic w_is_term;
    logic w_restart;

    assign w_ready   = (r_state == LOAD) && (r_wr_ptr != PTR_MAX);
    assign w_acc     = bus.in_valid && w_ready;
    assign w_is_term = (bus.in_data == TERM_CHAR);
    assign w_restart = bus.start && ((r_state == IDLE) || (r_state == DONE));

`ifdef ASCII_FILTER_EN
    logic              w_printable;
    logic [ADDR_W-1:0] r_dropped;

    ascii_printable_chk #(
        .DATA_W (DATA_W)
    ) u_chk (
        .i_ch (bus.in_data),
        .o_ok (w_printable)
    );

    // Dropped bytes are still consumed, so the sender never stalls on them.
    assign w_keep = w_printable || w_is_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dropped <= '0;
        end else if (w_restart) begin
            r_dropped <= '0;
        end else if (w_acc && !w_keep && (r_dropped != '1)) begin
            r_dropped <= r_dropped + 1'b1;
        end
    end

    assign bus.dropped_cnt = r_dropped;
`else
    assign w_keep = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_waddr    <= '0;
            r_din      <= '0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_length   <= '0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_restart) begin
                        r_state    <= LOAD;
                        r_wr_ptr   <= '0;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_length   <= '0;
                    end
                end
                LOAD: begin
                    if (r_wr_ptr == PTR_MAX) begin
                        r_state <= TERM;
                    end else if (w_acc && w_keep) begin
                        r_we     <= 1'b1;
                        r_waddr  <= r_wr_ptr;
                        r_din    <= bus.in_data;
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (w_is_term) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_length <= r_wr_ptr;
                        end
                    end
                end
                TERM: begin
                    // Capacity reached: force the terminator into the last word.
                    r_we       <= 1'b1;
                    r_waddr    <= PTR_MAX;
                    r_din      <= TERM_CHAR;
                    r_done     <= 1'b1;
                    r_overflow <= 1'b1;
                    r_length   <= PTR_MAX;
                    r_state    <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_waddr = r_waddr;
    assign bus.mem_din   = r_din;
    assign bus.busy      = (r_state == LOAD) || (r_state == TERM);
    assign bus.done      = r_done;
    assign bus.overflow  = r_overflow;
    assign bus.length    = r_length;

endmodule
